// File: rtl/micro_sequencer_if.sv
// Bundle of the sequencer's data/status signals; clk and reset stay plain ports.
// The bench drives through the master modport and the sequencer uses the slave modport.
interface micro_sequencer_if #(
  parameter int UADDR_W     = 5,
  parameter int CW_W        = 31,
  parameter int NUM_DISP    = 3,
  parameter int STACK_DEPTH = 2
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                         stall;
  logic                         overflow;
  logic [NUM_DISP*UADDR_W-1:0]  disp_addr;
  logic [NUM_DISP-1:0]          disp_valid;
  logic [CW_W+UADDR_W+2:0]      udata;
  logic [UADDR_W-1:0]           rom_addr;
  logic [CW_W-1:0]              ctrl_word;
  logic                         exc_valid;
  logic [1:0]                   exc_code;
  logic [DEPTH_W-1:0]           depth;

  modport master (
    output stall, overflow, disp_addr, disp_valid, udata,
    input  rom_addr, ctrl_word, exc_valid, exc_code, depth
  );

  modport slave (
    input  stall, overflow, disp_addr, disp_valid, udata,
    output rom_addr, ctrl_word, exc_valid, exc_code, depth
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: uPC, dispatch tables, bounded micro-return stack and
// exception redirection with a registered cause code and one-cycle pulse.
module micro_sequencer #(
  parameter int UADDR_W     = 5,
  parameter int CW_W        = 31,
  parameter int NUM_DISP    = 3,
  parameter int STACK_DEPTH = 2,
  parameter int EXC_ADDR    = 27
) (
  input  logic               clk,
  input  logic               reset,
  micro_sequencer_if.slave   bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  // Stack array sized to the full index range so r_depth indexes it directly.
  localparam int SLOTS   = 1 << DEPTH_W;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_NEXT   = 3'd1,
    SEQ_DISP0  = 3'd2,
    SEQ_DISP1  = 3'd3,
    SEQ_DISP2  = 3'd4,
    SEQ_CALL   = 3'd5,
    SEQ_RET    = 3'd6,
    SEQ_CHKOVF = 3'd7
  } seq_e;

  logic [UADDR_W-1:0] r_upc;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_exc_valid;
  logic [1:0]         r_exc_code;
  logic [UADDR_W-1:0] r_stack [SLOTS];

  seq_e               w_seq;
  logic [UADDR_W-1:0] w_target;
  logic [CW_W-1:0]    w_ctrl;
  logic [UADDR_W-1:0] w_upc_inc;
  logic [DEPTH_W-1:0] w_top;
  logic [2:0]         w_disp_n;
  logic               w_disp_ok;
  logic [UADDR_W-1:0] w_disp_tgt;
  logic [UADDR_W-1:0] w_next_upc;
  logic               w_exc;
  logic [1:0]         w_exc_code;
  logic               w_push;
  logic               w_pop;

  assign w_seq     = seq_e'(bus.udata[2:0]);
  assign w_target  = bus.udata[UADDR_W+2:3];
  assign w_ctrl    = bus.udata[CW_W+UADDR_W+2:UADDR_W+3];
  assign w_upc_inc = r_upc + UADDR_W'(1);
  assign w_top     = r_depth - DEPTH_W'(1);
  assign w_disp_n  = bus.udata[2:0] - 3'd2;

  assign bus.rom_addr  = r_upc;
  assign bus.ctrl_word = bus.stall ? {CW_W{1'b0}} : w_ctrl;
  assign bus.exc_valid = r_exc_valid;
  assign bus.exc_code  = r_exc_code;
  assign bus.depth     = r_depth;

  // Select the dispatch table named by the seq code, if it exists and is valid.
  always_comb begin
    w_disp_ok  = 1'b0;
    w_disp_tgt = {UADDR_W{1'b0}};
    for (int k = 0; k < NUM_DISP; k++) begin
      w_disp_ok  = w_disp_ok | ((w_disp_n == 3'(k)) & bus.disp_valid[k]);
      w_disp_tgt = (w_disp_n == 3'(k)) ? bus.disp_addr[k*UADDR_W +: UADDR_W] : w_disp_tgt;
    end
  end

  // Next-address and exception decode for the current microword.
  always_comb begin
    w_next_upc = {UADDR_W{1'b0}};
    w_exc      = 1'b0;
    w_exc_code = 2'd0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    case (w_seq)
      SEQ_FETCH: w_next_upc = {UADDR_W{1'b0}};
      SEQ_NEXT:  w_next_upc = w_upc_inc;
      SEQ_DISP0, SEQ_DISP1, SEQ_DISP2: begin
        if (w_disp_ok) begin
          w_next_upc = w_disp_tgt;
        end else begin
          w_next_upc = UADDR_W'(EXC_ADDR);
          w_exc      = 1'b1;
          w_exc_code = 2'd1;
        end
      end
      SEQ_CALL: begin
        if (r_depth == DEPTH_W'(STACK_DEPTH)) begin
          w_next_upc = UADDR_W'(EXC_ADDR);
          w_exc      = 1'b1;
          w_exc_code = 2'd3;
        end else begin
          w_next_upc = w_target;
          w_push     = 1'b1;
        end
      end
      SEQ_RET: begin
        if (r_depth == DEPTH_W'(0)) begin
          w_next_upc = UADDR_W'(EXC_ADDR);
          w_exc      = 1'b1;
          w_exc_code = 2'd3;
        end else begin
          w_next_upc = r_stack[w_top];
          w_pop      = 1'b1;
        end
      end
      SEQ_CHKOVF: begin
        if (bus.overflow) begin
          w_next_upc = UADDR_W'(EXC_ADDR);
          w_exc      = 1'b1;
          w_exc_code = 2'd2;
        end else begin
          w_next_upc = w_target;
        end
      end
      default: w_next_upc = {UADDR_W{1'b0}};
    endcase
  end

  // Sequencer state: stall freezes everything and suppresses the exception pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upc       <= {UADDR_W{1'b0}};
      r_depth     <= {DEPTH_W{1'b0}};
      r_exc_valid <= 1'b0;
      r_exc_code  <= 2'd0;
      for (int i = 0; i < SLOTS; i++) begin
        r_stack[i] <= {UADDR_W{1'b0}};
      end
    end else if (bus.stall) begin
      r_exc_valid <= 1'b0;
    end else begin
      r_upc       <= w_next_upc;
      r_exc_valid <= w_exc;
      if (w_exc) begin
        r_exc_code <= w_exc_code;
      end
      if (w_push) begin
        r_stack[r_depth] <= w_upc_inc;
        r_depth          <= r_depth + DEPTH_W'(1);
      end else if (w_pop) begin
        r_depth <= w_top;
      end
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a bench-owned ROM feeds udata, expected
// per-cycle state is queued with each step and checked after the clock edge.
module tb_micro_sequencer;
  localparam int UADDR_W = 5;
  localparam int CW_W    = 31;
  localparam int UW      = CW_W + UADDR_W + 3;

  localparam logic [2:0] S_FETCH = 3'd0, S_SEQ = 3'd1, S_D0 = 3'd2, S_D1 = 3'd3,
                         S_D2 = 3'd4, S_CALL = 3'd5, S_RET = 3'd6, S_CHK = 3'd7;

  typedef struct packed {
    logic [4:0] a;
    logic       v;
    logic [1:0] c;
    logic [1:0] d;
  } exp_t;

  logic clk;
  logic reset;
  logic [UW-1:0] rom [32];
  exp_t q[$];
  int errors;
  int checks;

  micro_sequencer_if #(.UADDR_W(5), .CW_W(31), .NUM_DISP(3), .STACK_DEPTH(2)) ifc ();

  micro_sequencer #(
    .UADDR_W(5), .CW_W(31), .NUM_DISP(3), .STACK_DEPTH(2), .EXC_ADDR(27)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  assign ifc.udata = rom[ifc.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [UW-1:0] mk(input logic [4:0] a, input logic [4:0] tgt,
                                       input logic [2:0] sq);
    logic [CW_W-1:0] ctrl;
    ctrl = 31'h0ABC_0000 | {26'd0, a};
    return {ctrl, tgt, sq};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    logic [UW-1:0] w;
    logic [CW_W-1:0] ectrl;
    e = q.pop_front();
    w = rom[e.a];
    ectrl = ifc.stall ? {CW_W{1'b0}} : w[UW-1:8];
    chk("rom_addr", 32'(ifc.rom_addr), 32'(e.a));
    chk("exc_valid", 32'(ifc.exc_valid), 32'(e.v));
    chk("exc_code", 32'(ifc.exc_code), 32'(e.c));
    chk("depth", 32'(ifc.depth), 32'(e.d));
    chk("ctrl_word", 32'(ifc.ctrl_word), 32'(ectrl));
  endtask

  task automatic step(input logic [4:0] a, input logic v, input logic [1:0] c,
                      input logic [1:0] d);
    q.push_back('{a: a, v: v, c: c, d: d});
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    q.push_back('{a: 5'd0, v: 1'b0, c: 2'd0, d: 2'd0});
    #1 compare_head();
    #1 reset = 1'b0;
  endtask

  task automatic set_disp(input int k, input logic [4:0] a);
    ifc.disp_addr[k*5 +: 5] = a;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    ifc.stall = 1'b0;
    ifc.overflow = 1'b0;
    ifc.disp_addr = 15'd0;
    ifc.disp_valid = 3'b101;
    for (int i = 0; i < 32; i++) rom[i] = mk(5'(i), 5'd0, S_FETCH);
    rom[0]  = mk(5'd0, 5'd0, S_SEQ);
    rom[1]  = mk(5'd1, 5'd0, S_D0);
    rom[12] = mk(5'd12, 5'd0, S_D1);
    rom[19] = mk(5'd19, 5'd0, S_CHK);
    rom[27] = mk(5'd27, 5'd0, S_D2);
    set_disp(0, 5'd12);
    set_disp(2, 5'd0);

    // Reset state, then SEQ and valid DISP0.
    @(posedge clk);
    @(posedge clk);
    #1;
    q.push_back('{a: 5'd0, v: 1'b0, c: 2'd0, d: 2'd0});
    compare_head();
    reset = 1'b0;
    step(5'd1, 1'b0, 2'd0, 2'd0);
    step(5'd12, 1'b0, 2'd0, 2'd0);

    // Invalid DISP1 -> exception code 1, held afterwards.
    step(5'd27, 1'b1, 2'd1, 2'd0);
    step(5'd0, 1'b0, 2'd1, 2'd0);

    // CHKOVF without and with overflow.
    set_disp(0, 5'd19);
    step(5'd1, 1'b0, 2'd1, 2'd0);
    step(5'd19, 1'b0, 2'd1, 2'd0);
    step(5'd0, 1'b0, 2'd1, 2'd0);
    step(5'd1, 1'b0, 2'd1, 2'd0);
    step(5'd19, 1'b0, 2'd1, 2'd0);
    ifc.overflow = 1'b1;
    step(5'd27, 1'b1, 2'd2, 2'd0);
    ifc.overflow = 1'b0;
    step(5'd0, 1'b0, 2'd2, 2'd0);

    // Stack overflow, then a back-to-back invalid-dispatch exception.
    set_disp(0, 5'd3);
    rom[3]  = mk(5'd3, 5'd8, S_CALL);
    rom[8]  = mk(5'd8, 5'd10, S_CALL);
    rom[10] = mk(5'd10, 5'd5, S_CALL);
    step(5'd1, 1'b0, 2'd2, 2'd0);
    step(5'd3, 1'b0, 2'd2, 2'd0);
    step(5'd8, 1'b0, 2'd2, 2'd1);
    step(5'd10, 1'b0, 2'd2, 2'd2);
    ifc.disp_valid = 3'b001;
    step(5'd27, 1'b1, 2'd3, 2'd2);
    step(5'd27, 1'b1, 2'd1, 2'd2);
    ifc.disp_valid = 3'b101;
    step(5'd0, 1'b0, 2'd1, 2'd2);
    pulse_reset();

    // RET from an empty stack.
    set_disp(0, 5'd6);
    rom[6] = mk(5'd6, 5'd0, S_RET);
    step(5'd1, 1'b0, 2'd0, 2'd0);
    step(5'd6, 1'b0, 2'd0, 2'd0);
    step(5'd27, 1'b1, 2'd3, 2'd0);
    step(5'd0, 1'b0, 2'd3, 2'd0);

    // CALL then RET, with a three-cycle stall (and overflow) on the RET.
    set_disp(0, 5'd3);
    rom[8] = mk(5'd8, 5'd0, S_RET);
    step(5'd1, 1'b0, 2'd3, 2'd0);
    step(5'd3, 1'b0, 2'd3, 2'd0);
    step(5'd8, 1'b0, 2'd3, 2'd1);
    ifc.stall = 1'b1;
    ifc.overflow = 1'b1;
    for (int i = 0; i < 3; i++) step(5'd8, 1'b0, 2'd3, 2'd1);
    ifc.stall = 1'b0;
    ifc.overflow = 1'b0;
    step(5'd4, 1'b0, 2'd3, 2'd0);
    step(5'd0, 1'b0, 2'd3, 2'd0);

    // CALL at the top address pushes the wrapped return address 0.
    set_disp(0, 5'd31);
    rom[31] = mk(5'd31, 5'd8, S_CALL);
    step(5'd1, 1'b0, 2'd3, 2'd0);
    step(5'd31, 1'b0, 2'd3, 2'd0);
    step(5'd8, 1'b0, 2'd3, 2'd1);
    step(5'd0, 1'b0, 2'd3, 2'd0);

    // Asynchronous reset at address 12 with one stacked entry.
    set_disp(0, 5'd3);
    rom[3] = mk(5'd3, 5'd12, S_CALL);
    step(5'd1, 1'b0, 2'd3, 2'd0);
    step(5'd3, 1'b0, 2'd3, 2'd0);
    step(5'd12, 1'b0, 2'd3, 2'd1);
    pulse_reset();
    step(5'd1, 1'b0, 2'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
